mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares one SRAM-style memory bus between the instruction-fetch port (IF) and the data-access port (MEM).
- Sequences each transaction with a req/ack handshake.
- Returns read data plus a one-cycle ready pulse to the winning requester.
- Generates per-stage stall requests that feed the pipeline stall controller.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width of all ports

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
flush  input  1  pipeline flush; cancels delivery of an in-flight fetch
inst_req  input  1  fetch request, held until inst_ready
inst_addr  input  ADDR_WIDTH  fetch address
inst_rdata  output  DATA_WIDTH  fetched word
inst_ready  output  1  one-cycle pulse: inst_rdata valid
data_req  input  1  load/store request, held until data_ready
data_we  input  1  1 = store
data_sel  input  DATA_WIDTH/8  byte enables
data_addr  input  ADDR_WIDTH  data address
data_wdata  input  DATA_WIDTH  store data
data_rdata  output  DATA_WIDTH  load data
data_ready  output  1  one-cycle pulse: access complete
bus_req  output  1  bus transaction valid
bus_we  output  1  bus write enable
bus_sel  output  DATA_WIDTH/8  bus byte enables
bus_addr  output  ADDR_WIDTH  bus address
bus_wdata  output  DATA_WIDTH  bus write data
bus_rdata  input  DATA_WIDTH  bus read data, valid with bus_ack
bus_ack  input  1  one-cycle completion strobe from the bus
stall_req_if  output  1  IF stage must stall
stall_req_mem  output  1  MEM stage must stall

Behaviour:
- Clock and reset: clk, rst; reset is synchronous and active-high.
- States: IDLE, INST_WAIT, DATA_WAIT, INST_DROP, RESP.
- Registered outputs: all bus_* outputs, inst_rdata, data_rdata, inst_ready and data_ready.
- Reset values: state IDLE, all bus_* 0, both rdata 0, both ready 0, last_grant = INST.
- IDLE grant, fetch only: latch inst_addr; bus_we=0; bus_sel all ones; go INST_WAIT.
- IDLE grant, data only: latch data_* onto bus_*; go DATA_WAIT.
- IDLE grant, both requests: grant the port that was not last_grant. This alternates and prevents starvation.
- IDLE grant, no request: stay in IDLE.
- On every grant: update last_grant; assert bus_req from the next cycle.
- WAIT states: hold bus_* stable until bus_ack.
- On bus_ack in a WAIT state: clear bus_req and capture bus_rdata into the matching rdata register. For a data store, data_rdata is left unchanged. Pulse the matching ready in the next cycle, which is the RESP cycle.
- RESP: lasts 1 cycle, ready high, no new grant; then IDLE.
- Minimum latency: request sampled at edge 0 → bus_req at cycle 1; ack at cycle k → ready at cycle k+1 → next grant decision at cycle k+2.
- flush in INST_WAIT: go INST_DROP. Keep bus_req until bus_ack, because bus transactions cannot be aborted. Then go IDLE with no inst_ready and inst_rdata unchanged.
- flush in RESP of a fetch: suppress inst_ready in that cycle.
- flush has no effect on data transactions.
- flush in IDLE has no effect other than blocking an inst grant that cycle.
- bus_ack in IDLE or RESP: ignored. This covers stray acks after reset mid-transaction.
- rst mid-transaction: forces IDLE and drops bus_req the next cycle. The outstanding bus transaction is abandoned.
- rdata registers hold their value until the next completing read on that port.
- stall_req_if = inst_req & ~inst_ready (combinational).
- stall_req_mem = data_req & ~data_ready (combinational).
- Requesters must hold address/data stable while req is high. A request dropped before ready is a protocol violation and is not checked.

Test Plan:
- Reset, then an inst_req at addr 0x100 with bus_ack 2 cycles after bus_req → bus_addr=0x100, bus_we=0, bus_sel=4'hF; inst_ready pulses once with inst_rdata=bus_rdata (0xDEADBEEF); stall_req_if high until that cycle.
- Simultaneous inst_req (0x200) and data_req (store 0x80, wdata 0x1234, sel 4'h3) after reset, last_grant=INST → data granted first, bus_we=1, bus_sel=4'h3; then fetch at 0x200; grants alternate on repeated contention.
- Continuous data_req with inst_req held → at most one data transaction between fetches; inst_ready observed within 2 transactions.
- flush asserted during INST_WAIT at 0x300, ack 3 cycles later → bus_req held until ack; no inst_ready; inst_rdata unchanged; next inst_req issued normally.
- rst asserted while DATA_WAIT, bus_ack arrives 1 cycle after reset releases → bus_req=0 after reset; data_ready never pulses; state IDLE.
- Zero-wait bus (ack the cycle bus_req rises) with back-to-back fetches → ready exactly 1 cycle after ack; one RESP gap cycle between transactions; no double issue while req is still high in the RESP cycle.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: fetch port, data port, SRAM bus and stall signals of the memory bus arbiter
interface mem_bus_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    flush;
  logic                    inst_req;
  logic [ADDR_WIDTH-1:0]   inst_addr;
  logic [DATA_WIDTH-1:0]   inst_rdata;
  logic                    inst_ready;
  logic                    data_req;
  logic                    data_we;
  logic [DATA_WIDTH/8-1:0] data_sel;
  logic [ADDR_WIDTH-1:0]   data_addr;
  logic [DATA_WIDTH-1:0]   data_wdata;
  logic [DATA_WIDTH-1:0]   data_rdata;
  logic                    data_ready;
  logic                    bus_req;
  logic                    bus_we;
  logic [DATA_WIDTH/8-1:0] bus_sel;
  logic [ADDR_WIDTH-1:0]   bus_addr;
  logic [DATA_WIDTH-1:0]   bus_wdata;
  logic [DATA_WIDTH-1:0]   bus_rdata;
  logic                    bus_ack;
  logic                    stall_req_if;
  logic                    stall_req_mem;
  modport slave (
    input  flush, inst_req, inst_addr, data_req, data_we, data_sel, data_addr, data_wdata, bus_rdata, bus_ack,
    output inst_rdata, inst_ready, data_rdata, data_ready, bus_req, bus_we, bus_sel, bus_addr, bus_wdata,
    output stall_req_if, stall_req_mem
  );
  modport master (
    output flush, inst_req, inst_addr, data_req, data_we, data_sel, data_addr, data_wdata, bus_rdata, bus_ack,
    input  inst_rdata, inst_ready, data_rdata, data_ready, bus_req, bus_we, bus_sel, bus_addr, bus_wdata,
    input  stall_req_if, stall_req_mem
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one SRAM bus between instruction fetch and data access with alternating priority
module mem_bus_arbiter (
  input logic              clk,
  input logic              rst,
  mem_bus_arbiter_if.slave mb
);
  typedef enum logic [2:0] {IDLE, INST_WAIT, DATA_WAIT, INST_DROP, RESP} state_t;
  typedef enum logic {G_INST, G_DATA} grant_t;
  state_t state, state_n;
  grant_t last_grant;
  logic   gnt_inst, gnt_data, done_inst, done_data, inst_ready_q, data_ready_q, inst_ready;
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  // grant decision and next state; a flushed fetch still waits out its bus ack in INST_DROP
  always_comb begin
    gnt_inst  = state == IDLE && mb.inst_req && !mb.flush && (!mb.data_req || last_grant == G_DATA);
    gnt_data  = state == IDLE && mb.data_req && !gnt_inst;
    done_inst = state == INST_WAIT && mb.bus_ack && !mb.flush;
    done_data = state == DATA_WAIT && mb.bus_ack;
    state_n   = state;
    case (state)
      IDLE:      state_n = gnt_inst ? INST_WAIT : gnt_data ? DATA_WAIT : IDLE;
      INST_WAIT: state_n = mb.bus_ack ? (mb.flush ? IDLE : RESP) : (mb.flush ? INST_DROP : INST_WAIT);
      DATA_WAIT: state_n = mb.bus_ack ? RESP : DATA_WAIT;
      INST_DROP: state_n = mb.bus_ack ? IDLE : INST_DROP;
      default:   state_n = IDLE;
    endcase
  end
  // bus launch on grant, bus release on ack, read data capture and ready pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant    <= G_INST;
      mb.bus_req    <= 1'b0;
      mb.bus_we     <= 1'b0;
      mb.bus_sel    <= '0;
      mb.bus_addr   <= '0;
      mb.bus_wdata  <= '0;
      mb.inst_rdata <= '0;
      mb.data_rdata <= '0;
      inst_ready_q  <= 1'b0;
      data_ready_q  <= 1'b0;
    end else begin
      inst_ready_q <= done_inst;
      data_ready_q <= done_data;
      if (gnt_inst || gnt_data) begin
        last_grant   <= gnt_data ? G_DATA : G_INST;
        mb.bus_req   <= 1'b1;
        mb.bus_we    <= gnt_data && mb.data_we;
        mb.bus_sel   <= gnt_data ? mb.data_sel : '1;
        mb.bus_addr  <= gnt_data ? mb.data_addr : mb.inst_addr;
        mb.bus_wdata <= gnt_data ? mb.data_wdata : '0;
      end else if (mb.bus_ack && (state == INST_WAIT || state == DATA_WAIT || state == INST_DROP))
        mb.bus_req <= 1'b0;
      if (done_inst) mb.inst_rdata <= mb.bus_rdata;
      if (done_data && !mb.bus_we) mb.data_rdata <= mb.bus_rdata;
    end
  end
  assign inst_ready       = inst_ready_q && !mb.flush;
  assign mb.inst_ready    = inst_ready;
  assign mb.data_ready    = data_ready_q;
  assign mb.stall_req_if  = mb.inst_req && !inst_ready;
  assign mb.stall_req_mem = mb.data_req && !data_ready_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: scoreboard bench with bus responder and two requesters for mem_bus_arbiter
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mem_bus_arbiter_if mb ();
  mem_bus_arbiter dut (.clk(clk), .rst(rst), .mb(mb));
  typedef struct packed {logic we; logic [3:0] sel; logic [31:0] addr; logic [31:0] wdata;} txn_t;
  txn_t        exp_bus[$], dq[$], held;
  logic [31:0] iq[$], exp_inst[$], exp_data[$], model_ir, model_dr;
  int          rises[$];
  int          vectors, miscompares, cyc, ack_cyc, ack_dly, cnt;
  bit          auto_ack, prev_req, i_done, d_done;

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return a == 32'h100 ? 32'hDEADBEEF : {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  function automatic txn_t mk(input logic we, input logic [3:0] sel, input logic [31:0] a, input logic [31:0] wd);
    txn_t t;
    t.we = we;
    t.sel = sel;
    t.addr = a;
    t.wdata = we ? wd : 32'h0;
    return t;
  endfunction

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic fetch(input logic [31:0] a);
    iq.push_back(a);
    exp_bus.push_back(mk(1'b0, 4'hF, a, 32'h0));
    model_ir = rd_word(a);
    exp_inst.push_back(model_ir);
  endtask

  task automatic access(input logic we, input logic [3:0] sel, input logic [31:0] a, input logic [31:0] wd);
    dq.push_back(mk(we, sel, a, wd));
    exp_bus.push_back(mk(we, sel, a, wd));
    if (!we) model_dr = rd_word(a);
    exp_data.push_back(model_dr);
  endtask

  task automatic step(input bit fl = 1'b0);
    txn_t c;
    @(posedge clk);
    #1;
    mb.flush = fl;
    mb.bus_ack = 1'b0;
    if (!mb.bus_req) cnt = 0;
    else if (auto_ack && cnt == ack_dly) begin
      mb.bus_ack = 1'b1;
      mb.bus_rdata = rd_word(mb.bus_addr);
      cnt = 0;
    end else cnt++;
    if (i_done) begin
      mb.inst_req = 1'b0;
      i_done = 1'b0;
    end
    if (!mb.inst_req && iq.size() > 0) begin
      mb.inst_req = 1'b1;
      mb.inst_addr = iq.pop_front();
    end
    if (d_done) begin
      mb.data_req = 1'b0;
      d_done = 1'b0;
    end
    if (!mb.data_req && dq.size() > 0) begin
      c = dq.pop_front();
      mb.data_req = 1'b1;
      mb.data_we = c.we;
      mb.data_sel = c.sel;
      mb.data_addr = c.addr;
      mb.data_wdata = c.wdata;
    end
    @(negedge clk);
    cyc++;
    if (mb.bus_ack) ack_cyc = cyc;
    if (mb.bus_req && !prev_req) begin
      rises.push_back(cyc);
      held = mk(mb.bus_we, mb.bus_sel, mb.bus_addr, mb.bus_wdata);
      if (exp_bus.size() == 0) chk("bus_extra", 1, 0);
      else chk("bus_txn", held, exp_bus.pop_front());
    end else if (mb.bus_req) chk("bus_hold", mk(mb.bus_we, mb.bus_sel, mb.bus_addr, mb.bus_wdata), held);
    prev_req = mb.bus_req;
    if (mb.inst_ready) begin
      if (exp_inst.size() == 0) chk("inst_extra", 1, 0);
      else chk("inst_rdata", mb.inst_rdata, exp_inst.pop_front());
      chk("inst_lat", cyc - ack_cyc, 1);
      if (mb.inst_req) i_done = 1'b1;
    end
    if (mb.data_ready) begin
      if (exp_data.size() == 0) chk("data_extra", 1, 0);
      else chk("data_rdata", mb.data_rdata, exp_data.pop_front());
      chk("data_lat", cyc - ack_cyc, 1);
      if (mb.data_req) d_done = 1'b1;
    end
    chk("stall_if", mb.stall_req_if, mb.inst_req & ~mb.inst_ready);
    chk("stall_mem", mb.stall_req_mem, mb.data_req & ~mb.data_ready);
  endtask

  function automatic bit quiet();
    return iq.size() == 0 && dq.size() == 0 && !mb.inst_req && !mb.data_req && !mb.bus_req &&
           exp_bus.size() == 0 && exp_inst.size() == 0 && exp_data.size() == 0;
  endfunction

  task automatic run(input int n);
    for (int k = 0; k < n && !quiet(); k++) step();
    chk("drain", quiet(), 1);
    step();
    step();
  endtask

  initial begin
    int n0;
    mb.flush = 1'b0;
    mb.inst_req = 1'b0;
    mb.inst_addr = '0;
    mb.data_req = 1'b0;
    mb.data_we = 1'b0;
    mb.data_sel = '0;
    mb.data_addr = '0;
    mb.data_wdata = '0;
    mb.bus_rdata = '0;
    mb.bus_ack = 1'b0;
    auto_ack = 1'b1;
    model_ir = '0;
    model_dr = '0;
    step();
    step();
    chk("rst_bus_req", mb.bus_req, 0);
    chk("rst_bus_we", mb.bus_we, 0);
    chk("rst_bus_addr", mb.bus_addr, 0);
    chk("rst_bus_sel", mb.bus_sel, 0);
    chk("rst_inst_ready", mb.inst_ready, 0);
    chk("rst_data_ready", mb.data_ready, 0);
    chk("rst_inst_rdata", mb.inst_rdata, 0);
    chk("rst_data_rdata", mb.data_rdata, 0);
    rst = 1'b0;
    ack_dly = 2;
    fetch(32'h100);
    step();
    step();
    chk("stall_if_pending", mb.stall_req_if, 1);
    run(100);
    ack_dly = 1;
    access(1'b1, 4'h3, 32'h80, 32'h1234);
    fetch(32'h200);
    run(100);
    access(1'b0, 4'hF, 32'h84, 32'h0);
    fetch(32'h204);
    access(1'b0, 4'hF, 32'h88, 32'h0);
    fetch(32'h208);
    access(1'b1, 4'hC, 32'h8C, 32'hA5A5_0000);
    access(1'b0, 4'hF, 32'h90, 32'h0);
    run(200);
    ack_dly = 3;
    mb.inst_addr = 32'h300;
    mb.inst_req = 1'b1;
    exp_bus.push_back(mk(1'b0, 4'hF, 32'h300, 32'h0));
    for (int k = 0; k < 10 && !mb.bus_req; k++) step();
    chk("flush_req", mb.bus_req, 1);
    step(1'b1);
    mb.inst_req = 1'b0;
    for (int k = 0; k < 10 && mb.bus_req; k++) step();
    chk("flush_hold", cyc - rises[$], 4);
    step();
    step();
    chk("flush_rdata", mb.inst_rdata, model_ir);
    fetch(32'h304);
    run(100);
    ack_dly = 1;
    mb.inst_addr = 32'h400;
    mb.inst_req = 1'b1;
    exp_bus.push_back(mk(1'b0, 4'hF, 32'h400, 32'h0));
    for (int k = 0; k < 10 && !mb.bus_ack; k++) step();
    chk("resp_ack", mb.bus_ack, 1);
    step(1'b1);
    mb.inst_req = 1'b0;
    step();
    model_ir = rd_word(32'h400);
    chk("resp_rdata", mb.inst_rdata, model_ir);
    run(50);
    auto_ack = 1'b0;
    mb.data_we = 1'b0;
    mb.data_sel = 4'hF;
    mb.data_addr = 32'h500;
    mb.data_req = 1'b1;
    exp_bus.push_back(mk(1'b0, 4'hF, 32'h500, 32'h0));
    for (int k = 0; k < 10 && !mb.bus_req; k++) step();
    chk("rst_mid_req", mb.bus_req, 1);
    step();
    step();
    rst = 1'b1;
    step();
    chk("rst_mid_drop", mb.bus_req, 0);
    rst = 1'b0;
    mb.data_req = 1'b0;
    model_ir = '0;
    model_dr = '0;
    step();
    mb.bus_ack = 1'b1;
    mb.bus_rdata = 32'hBAD0BAD0;
    step();
    step();
    step();
    chk("rst_bus_idle", mb.bus_req, 0);
    chk("rst_mid_drdata", mb.data_rdata, 0);
    chk("rst_mid_irdata", mb.inst_rdata, 0);
    auto_ack = 1'b1;
    access(1'b0, 4'hF, 32'h504, 32'h0);
    fetch(32'h600);
    run(100);
    ack_dly = 0;
    n0 = rises.size();
    fetch(32'h700);
    fetch(32'h704);
    fetch(32'h708);
    run(100);
    chk("zw_count", rises.size() - n0, 3);
    if (rises.size() >= n0 + 3) begin
      chk("zw_gap1", rises[n0+1] - rises[n0], 3);
      chk("zw_gap2", rises[n0+2] - rises[n0+1], 3);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
